cv32e40p_obi_mem_responder: RTL and testbench

Memory-side responder for the core's OBI-style data/instruction bus. It sits downstream of the PMP gate and answers req/gnt transactions issued by the core. It provides a word-addressed SRAM, configurable grant stall, in-order buffering of outstanding responses, and an error response for out-of-range accesses. It serves as the bus slave in core-level simulation and as a tightly-coupled memory in small SoC builds.

---
 rtl/cv32e40p_pkg.sv | 34 +++
 rtl/cv32e40p_obi_resp_fifo.sv | 52 +++++
 rtl/cv32e40p_obi_mem_responder.sv | 117 +++++++++++
 tb/tb_cv32e40p_obi_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared OBI response types, grant FSM states and byte-lane helper for the
// memory responder.
package cv32e40p_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = 4;
    localparam int unsigned OBI_RESP_W = OBI_DATA_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } gnt_state_e;

    // Packing order {err, rdata}: err is the MSB of the FIFO word.
    typedef struct packed {
        logic                  err;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_resp_t;

    function automatic logic [OBI_DATA_W-1:0] be_merge(
        input logic [OBI_DATA_W-1:0] old_word,
        input logic [OBI_DATA_W-1:0] new_word,
        input logic [OBI_BE_W-1:0]   be
    );
        logic [OBI_DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < OBI_BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response buffer; pointers wrap modulo DEPTH, which need not be a
// power of two.
module cv32e40p_obi_resp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
            else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop_i |-> !empty_o);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) push_i |-> !full_o);

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI slave: word SRAM with optional grant stall, buffered in-order responses
// and error replies for addresses outside the SRAM window.
module cv32e40p_obi_mem_responder
    import cv32e40p_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned GNT_STALL       = 0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        resp_stall_i
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GNT_STALL);

    logic [31:0]      mem_q [MEM_WORDS];
    gnt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt, accept, full, empty, in_range;
    logic [32:0]      addr_ext, lo_ext, hi_ext;
    logic [31:0]      offset;
    logic [IDX_W-1:0] index;
    obi_resp_t        push_data, head;

    // 33-bit compare keeps the upper bound from wrapping near 4 GiB.
    assign addr_ext = {1'b0, addr_i};
    assign lo_ext   = {1'b0, ADDR_BASE};
    assign hi_ext   = lo_ext + 33'(4 * MEM_WORDS);
    assign in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);
    assign offset   = addr_i - ADDR_BASE;
    assign index    = IDX_W'(offset >> 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (GNT_STALL == 0) begin
            gnt = req_i & ~full;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_i && !full) begin
                        state_d = STALL;
                        cnt_d   = CNT_W'(1);
                    end
                end
                STALL: begin
                    gnt = req_i & (cnt_q == CNT_MAX) & ~full;
                    if (!req_i || gnt) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o  = gnt & ~rst;
    assign accept = req_i & gnt_o;

    always_ff @(posedge clk) begin
        if (accept && we_i && in_range) mem_q[index] <= be_merge(mem_q[index], wdata_i, be_i);
    end

    // Read data is sampled before the same-edge write lands.
    always_comb begin
        push_data.err   = ~in_range;
        push_data.rdata = (in_range && !we_i) ? mem_q[index] : '0;
    end

    cv32e40p_obi_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (OBI_RESP_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .data_i  (push_data),
        .pop_i   (rvalid_o),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rvalid_o = ~empty & ~resp_stall_i & ~rst;
    assign rdata_o  = rvalid_o ? head.rdata : '0;
    assign err_o    = rvalid_o & head.err;

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (req_i && !gnt_o) |=> (!req_i || $stable({addr_i, we_i, be_i, wdata_i})));

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for the OBI memory responder: two instances (no stall / 3-cycle stall)
// checked every cycle against a queue-based model plus directed literals.
module tb_cv32e40p_obi_mem_responder;

    localparam int MW   = 16;
    localparam int MAXO = 2;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0, we = '0, stall = '0;
    logic [1:0]  gnt, rvalid, err;
    logic [31:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];

    int          total = 0;
    int          bad = 0;
    exp_t        q [2][$];
    logic [31:0] mmem [2][MW];
    int          h [2];
    bit          acc [2];

    always #5 clk = ~clk;

    cv32e40p_obi_mem_responder #(
        .ADDR_BASE(32'h0000_0000), .MEM_WORDS(MW), .GNT_STALL(0), .MAX_OUTSTANDING(MAXO)
    ) u_a (
        .clk(clk), .rst(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]), .resp_stall_i(stall[0])
    );

    cv32e40p_obi_mem_responder #(
        .ADDR_BASE(32'h0000_0100), .MEM_WORDS(MW), .GNT_STALL(3), .MAX_OUTSTANDING(MAXO)
    ) u_b (
        .clk(clk), .rst(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]), .resp_stall_i(stall[1])
    );

    function automatic longint base_of(input int i);
        return (i == 0) ? 64'h0 : 64'h100;
    endfunction

    function automatic int stall_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model of one accepted transfer: plain address arithmetic over a word array.
    task automatic model_access(input int i);
        longint a, lo;
        int     idx;
        exp_t   e;
        a  = longint'(addr[i]);
        lo = base_of(i);
        e  = '0;
        if (a >= lo && a < lo + 4 * MW) begin
            idx = int'((a - lo) / 4);
            if (we[i]) begin
                for (int b = 0; b < 4; b++)
                    if (be[i][b]) mmem[i][idx][8*b +: 8] = wdata[i][8*b +: 8];
            end else begin
                e.rdata = mmem[i][idx];
            end
        end else begin
            e.err = 1'b1;
        end
        q[i].push_back(e);
    endtask

    bit   m_full, m_gnt, m_vld;
    int   m_hc;
    exp_t m_e;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_e = '0;
            if (rst) begin
                q[i].delete();
                h[i]   = 0;
                acc[i] = 1'b0;
                m_gnt  = 1'b0;
                m_vld  = 1'b0;
            end else begin
                m_full = (q[i].size() >= MAXO);
                m_hc   = (req[i] && (h[i] > 0 || !m_full)) ? h[i] + 1 : 0;
                m_gnt  = req[i] && !m_full && (m_hc >= stall_of(i) + 1);
                m_vld  = (q[i].size() > 0) && !stall[i];
                if (m_vld) m_e = q[i][0];
                h[i]   = m_gnt ? 0 : m_hc;
                acc[i] = m_gnt;
            end
            check($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(m_gnt));
            check($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(m_vld));
            check($sformatf("rdata%0d", i), rdata[i], m_e.rdata);
            check($sformatf("err%0d", i), 32'(err[i]), 32'(m_e.err));
            if (m_vld) void'(q[i].pop_front());
            if (m_gnt) model_access(i);
        end
    end

    task automatic start(input int i, input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    endtask

    task automatic wait_acc(input int i, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!acc[i] && n < 60);
        if (!acc[i]) begin
            total++; bad++;
            $display("FAIL acc_timeout%0d actual=%0d cycles expected=grant", i, n);
        end
    endtask

    task automatic xfer(input int i, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, output int n);
        start(i, w, a, b, d);
        wait_acc(i, n);
        req[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; be[i] = '0; wdata[i] = '0; h[i] = 0; acc[i] = 1'b0;
        end
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic write then read, same-cycle grant and 1-cycle read latency.
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, n);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, n);
        check("a_gnt_latency", n, 1);
        @(negedge clk);
        check("a_rd_valid", 32'(rvalid[0]), 32'd1);
        check("a_rd_data", rdata[0], 32'hDEADBEEF);
        check("a_rd_err", 32'(err[0]), 32'd0);
        step();

        // Byte-enable merge.
        xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, n);
        xfer(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, n);
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, n);
        @(negedge clk);
        check("a_be_data", rdata[0], 32'h11BB33DD);
        step();

        // Out-of-range read errors; out-of-range write must not alias word 0.
        xfer(0, 1'b1, 32'h00, 4'hF, 32'h5A5A0001, n);
        xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, n);
        @(negedge clk);
        check("a_oor_err", 32'(err[0]), 32'd1);
        check("a_oor_data", rdata[0], 32'h0);
        step();
        xfer(0, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, n);
        xfer(0, 1'b0, 32'h00, 4'hF, 32'h0, n);
        @(negedge clk);
        check("a_oor_nowrite", rdata[0], 32'h5A5A0001);
        step();

        // Back-pressure: two reads fill the buffer, the third waits.
        stall[0] = 1'b1;
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, n);
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, n);
        start(0, 1'b0, 32'h00, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_gnt_held", 32'(gnt[0]), 32'd0);
            check("bp_rvalid_held", 32'(rvalid[0]), 32'd0);
            step();
        end
        stall[0] = 1'b0;
        @(negedge clk);
        check("bp_r1", rdata[0], 32'hDEADBEEF);
        check("bp_gnt_full", 32'(gnt[0]), 32'd0);
        step();
        @(negedge clk);
        check("bp_r2", rdata[0], 32'h11BB33DD);
        check("bp_gnt_third", 32'(gnt[0]), 32'd1);
        step();
        req[0] = 1'b0;
        @(negedge clk);
        check("bp_r3", rdata[0], 32'h5A5A0001);
        step();

        // Reset with two responses queued discards them.
        stall[0] = 1'b1;
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, n);
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, n);
        start(0, 1'b0, 32'h00, 4'hF, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rvalid", 32'(rvalid[0]), 32'd0);
        check("rst_mid_gnt", 32'(gnt[0]), 32'd0);
        step();
        rst = 1'b0;
        stall[0] = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid", 32'(rvalid[0]), 32'd0);
        check("post_rst_gnt", 32'(gnt[0]), 32'd1);
        step();
        req[0] = 1'b0;
        @(negedge clk);
        check("post_rst_data", rdata[0], 32'h5A5A0001);
        repeat (4) step();

        // Stalled grant: rises in the 4th cycle of a held request.
        start(1, 1'b1, 32'h13C, 4'hF, 32'hCAFEF00D);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("b_gnt_c%0d", k), 32'(gnt[1]), (k == 4) ? 32'd1 : 32'd0);
            step();
        end
        req[1] = 1'b0;
        xfer(1, 1'b0, 32'h13C, 4'hF, 32'h0, n);
        check("b_rd_latency", n, 4);
        @(negedge clk);
        check("b_rd_data", rdata[1], 32'hCAFEF00D);
        step();

        // Dropped request resets the stall count.
        start(1, 1'b0, 32'h13C, 4'hF, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("b_drop_gnt", 32'(gnt[1]), 32'd0);
            step();
        end
        req[1] = 1'b0;
        step();
        xfer(1, 1'b0, 32'h13C, 4'hF, 32'h0, n);
        check("b_regrant", n, 4);
        step();

        // Range edges below base and past the top.
        xfer(1, 1'b0, 32'hFC, 4'hF, 32'h0, n);
        @(negedge clk);
        check("b_below_err", 32'(err[1]), 32'd1);
        step();
        xfer(1, 1'b0, 32'h140, 4'hF, 32'h0, n);
        @(negedge clk);
        check("b_above_err", 32'(err[1]), 32'd1);
        check("b_above_data", rdata[1], 32'h0);
        repeat (5) step();

        check("a_drained", q[0].size(), 0);
        check("b_drained", q[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
